// File: rtl/fpu_mds_pkg.sv
// Shared encodings and state type for the mul/div/sqrt scheduler.
package fpu_mds_pkg;

   localparam logic [1:0] MDS_MUL  = 2'b00;
   localparam logic [1:0] MDS_DIV  = 2'b01;
   localparam logic [1:0] MDS_SQRT = 2'b10;
   localparam logic [1:0] MDS_ILL  = 2'b11;

   localparam logic [31:0] CANON_NAN = 32'h7FC00000;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam logic [4:0] FLAGS_INVALID = 5'(1 << FLAG_NV);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

endpackage

// File: rtl/mds_rr_arb.sv
// Two-port round-robin arbiter with last-served tracking.
module mds_rr_arb (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       update,
   input  logic       served,
   output logic [1:0] grant
);

   // Reset value 1 gives port 0 priority on the first contention.
   logic last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last <= 1'b1;
      end else if (update) begin
         last <= served;
      end
   end

   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/fpu_mds_sched.sv
// Two-port scheduler for a shared FP mul/div/sqrt unit,
// one operation in flight, with a WAIT timeout abort.
module fpu_mds_sched
   import fpu_mds_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [3:0]  req_op,
   input  logic [5:0]  req_rm,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   output logic        mds_start,
   output logic [1:0]  mds_op,
   output logic [2:0]  mds_rm,
   output logic [31:0] mds_a,
   output logic [31:0] mds_b,
   input  logic        mds_done,
   input  logic [31:0] mds_result,
   input  logic [4:0]  mds_flags,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic [4:0]  rsp_flags,
   output logic        rsp_timeout,
   output logic        busy
);

   localparam int CW =
      (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t state, state_d;
   logic [CW-1:0] cnt;
   logic [1:0] grant;
   logic accept, sel;
   logic [1:0] op_sel;
   logic timed_out;

   mds_rr_arb u_arb (
      .clk    (clk),
      .reset  (reset),
      .valid  (req_valid),
      .update (rsp_valid & rsp_ready),
      .served (rsp_id),
      .grant  (grant)
   );

   assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
   assign accept    = |(req_valid & req_ready);
   assign sel       = req_ready[1];
   assign op_sel    = sel ? req_op[3:2] : req_op[1:0];
   assign timed_out = (cnt == CNT_LAST);

   assign mds_start = (state == ST_ISSUE);
   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);

   always_comb begin
      state_d = state;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               state_d = (op_sel == MDS_ILL) ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (mds_done || timed_out) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         mds_op      <= '0;
         mds_rm      <= '0;
         mds_a       <= '0;
         mds_b       <= '0;
         rsp_id      <= 1'b0;
         rsp_result  <= '0;
         rsp_flags   <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         state <= state_d;
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  mds_op <= op_sel;
                  mds_rm <= sel ? req_rm[5:3] : req_rm[2:0];
                  mds_a  <= sel ? req_a[63:32] : req_a[31:0];
                  mds_b  <= sel ? req_b[63:32] : req_b[31:0];
                  rsp_id <= sel;
                  // Illegal op answers immediately without the unit.
                  if (op_sel == MDS_ILL) begin
                     rsp_result  <= CANON_NAN;
                     rsp_flags   <= FLAGS_INVALID;
                     rsp_timeout <= 1'b0;
                  end
               end
            end
            ST_ISSUE: cnt <= '0;
            ST_WAIT: begin
               if (mds_done) begin
                  rsp_result  <= mds_result;
                  rsp_flags   <= mds_flags;
                  rsp_timeout <= 1'b0;
               end else if (timed_out) begin
                  rsp_result  <= CANON_NAN;
                  rsp_flags   <= '0;
                  rsp_timeout <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
